sample_clk_gen: RTL and testbench
=================================

Name: sample_clk_gen

Overview:
- Parametrised successor to the fixed-table sample clock divider that drives the back-plane sample clock.
- Divides clk_in down to one of ten standard sample rates, from 100 kSPS to 100 SPS, or to a custom rate set by a run-time half-period value.
- Adds glitch-free rate switching, a stop mode, a one-cycle sample strobe, an active-rate readback and a sample counter for the acquisition logic.

Parameters:
- CLK_FREQ_HZ, 100000000, frequency of clk_in. The table half-period for each rate is CLK_FREQ_HZ/(2*rate).
- CNT_W, 32, width of the divide counter and of div_half.
- SCNT_W, 16, width of sample_count.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  reset, active-low, asynchronous.
- en  input  1  count enable. When 0, the counter and clk_out freeze.
- sync_clr  input  1  synchronous restart pulse.
- sel  input  4  rate code.
  - 1=100k, 2=50k, 3=20k, 4=10k, 5=5k, 6=2k, 7=1k, 8=500, 9=200, 10=100 SPS.
  - 15=custom rate.
  - 0 and 11-14 = stop.
- div_half  input  CNT_W  custom half-period in clk_in cycles. Used only when the applied code is 15.
- clk_out  output  1  generated sample clock, 50% duty cycle.
- sample_stb  output  1  one-cycle pulse, asserted in the same cycle clk_out rises.
- active_sel  output  4  rate code currently applied. Reads 0 when stopped.
- switch_pending  output  1  sel differs from active_sel and the change has not yet been applied.
- sample_count  output  SCNT_W  number of sample_stb pulses, wraps.

Behaviour:
- Reset: rst=0 asynchronously forces:
  - clk_out=0, sample_stb=0, active_sel=0, switch_pending=0, sample_count=0;
  - internal cnt=0 and shadow half-period=0.
- Priority: rst > sync_clr > en.
- All outputs are registered and all update on the posedge of clk_in.
- Applied half-period H:
  - code 1-10: table value, e.g. 500 for code 1 and 500000 for code 10 at 100 MHz;
  - code 15: div_half, latched into the shadow register at the moment of application;
  - code 15 with div_half=0, and every invalid code: treated as stop.
- Running (active_sel!=0, en=1):
  - cnt increments every cycle;
  - when cnt==H-1, cnt<=0 and clk_out toggles;
  - a low-to-high toggle also asserts sample_stb for that one cycle and increments sample_count (modulo 2^SCNT_W).
- Switching boundary: sel is compared with active_sel every cycle. A new code is applied only at the rising-edge boundary (cnt==H-1 with clk_out=0). At that boundary:
  - new code valid: active_sel<=sel and the new H is latched; clk_out still rises and sample_stb still fires; the high phase uses the new H. No runt pulse is ever produced.
  - new code is stop: clk_out stays 0, no strobe, active_sel<=0, cnt<=0.
- Stopped (active_sel==0):
  - clk_out is held at 0;
  - a valid sel is applied on the next cycle with cnt=0;
  - the first rising edge occurs H cycles after application.
- Custom mode: div_half changes while code 15 is already active take effect only at the next rising-edge boundary. The shadow value is refreshed at every boundary.
- en=0: cnt, clk_out and the pending logic hold; sample_stb=0. Counting resumes from the held cnt when en returns to 1.
- sync_clr=1, synchronous: cnt<=0, clk_out<=0, sample_stb<=0, sample_count<=0. active_sel<=sel immediately, or 0 if sel is invalid.
- switch_pending: combinational-free registered flag, equal to (sel_valid_or_stop_code != active_sel) from the previous cycle. It clears in the cycle after application.
- Minimum H is 1, which gives clk_out = clk_in/2. H up to 2^CNT_W-1 must be supported without overflow.

Test Plan:
1. Release rst with sel=1, en=1:
   - active_sel=1 after one cycle;
   - first clk_out rise 500 cycles later, with sample_stb high for exactly that cycle;
   - clk_out period 1000 cycles, duty 500/500.
2. Running at sel=1, change to sel=2 mid high phase:
   - switch_pending=1 until the next rising edge;
   - that edge still occurs 1000 cycles after the prior one;
   - subsequent period is 2000 cycles; no pulse shorter than 500 cycles.
3. sel=15 with div_half=3:
   - clk_out period 6 cycles;
   - change div_half to 5 mid-cycle: old period completes, then period 10.
4. Running at sel=4, set sel=0:
   - at the next rising boundary clk_out stays low, no strobe, active_sel=0;
   - set sel=1 again: first rise after 500 cycles.
5. SCNT_W=8 with custom div_half=1:
   - sample_count goes 255 to 0 on the 256th strobe;
   - sync_clr pulse mid-count zeroes cnt, clk_out and sample_count the next cycle.
6. Running at sel=3, drop en for 100 cycles:
   - clk_out and cnt hold, no strobes;
   - assert rst=0 mid-high-phase: all outputs go to 0 without waiting for a clock.

Source files
------------

// File: rtl/sample_clk_gen_if.sv
// ---------------------------------------------------------------------------
// sample_clk_gen_if
// Groups the control inputs and status outputs of sample_clk_gen.
//   en, sync_clr     : count enable and synchronous restart
//   sel, div_half    : requested rate code and custom half-period
//   clk_out          : generated sample clock (50% duty)
//   sample_stb       : one-cycle pulse on each clk_out rising edge
//   active_sel       : rate code currently applied (0 when stopped)
//   switch_pending   : requested code not yet applied
//   sample_count     : wrapping count of sample_stb pulses
// master = acquisition/control side, slave = the generator.
// ---------------------------------------------------------------------------
interface sample_clk_gen_if #(
  parameter int CNT_W  = 32,
  parameter int SCNT_W = 16
) ();
  logic              en;
  logic              sync_clr;
  logic [3:0]        sel;
  logic [CNT_W-1:0]  div_half;
  logic              clk_out;
  logic              sample_stb;
  logic [3:0]        active_sel;
  logic              switch_pending;
  logic [SCNT_W-1:0] sample_count;

  modport master (
    output en, sync_clr, sel, div_half,
    input  clk_out, sample_stb, active_sel, switch_pending, sample_count
  );

  modport slave (
    input  en, sync_clr, sel, div_half,
    output clk_out, sample_stb, active_sel, switch_pending, sample_count
  );
endinterface

// File: rtl/sample_clk_gen.sv
// ---------------------------------------------------------------------------
// sample_clk_gen
// Divides clk_in down to one of ten standard sample rates (100 kSPS..100 SPS)
// or a custom rate given as a half-period in clk_in cycles. Rate changes are
// applied only at a rising-edge boundary, so clk_out never produces a runt.
// Ports:
//   clk_in : system clock
//   rst    : asynchronous active-low reset
//   bus    : sample_clk_gen_if.slave (controls, clock output and status)
// ---------------------------------------------------------------------------
module sample_clk_gen #(
  parameter longint unsigned CLK_FREQ_HZ = 100000000,
  parameter int              CNT_W       = 32,
  parameter int              SCNT_W      = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  sample_clk_gen_if.slave   bus
);

  // Half-period for a table rate code; 0 marks codes that are not table rates.
  function automatic logic [CNT_W-1:0] rate_half(input int code);
    longint unsigned rate;
    case (code)
      1:       rate = 64'd100000;
      2:       rate = 64'd50000;
      3:       rate = 64'd20000;
      4:       rate = 64'd10000;
      5:       rate = 64'd5000;
      6:       rate = 64'd2000;
      7:       rate = 64'd1000;
      8:       rate = 64'd500;
      9:       rate = 64'd200;
      10:      rate = 64'd100;
      default: rate = 64'd0;
    endcase
    if (rate == 64'd0) return '0;
    return CNT_W'(CLK_FREQ_HZ / (64'd2 * rate));
  endfunction

  logic [CNT_W-1:0] half_tbl [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_half_tbl
    assign half_tbl[gi] = rate_half(gi);
  end

  // State
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  half_q,   half_d;    // shadow half-period of active code
  logic              clk_q,    clk_d;
  logic              stb_q,    stb_d;
  logic [3:0]        active_q, active_d;
  logic              pend_q,   pend_d;
  logic [SCNT_W-1:0] scnt_q,   scnt_d;

  // Requested code reduced to what it would apply: any code whose half-period
  // resolves to zero (invalid codes, custom with div_half=0) means stop.
  logic [CNT_W-1:0] half_eff;
  logic [3:0]       sel_eff;
  logic             at_term;

  always_comb begin
    half_eff = (bus.sel == 4'd15) ? bus.div_half : half_tbl[bus.sel];
    sel_eff  = (half_eff != '0) ? bus.sel : 4'd0;
  end

  // half_q is never zero while running, so H-1 cannot underflow.
  assign at_term = (cnt_q == (half_q - CNT_W'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    clk_d    = clk_q;
    stb_d    = 1'b0;
    active_d = active_q;
    pend_d   = pend_q;
    scnt_d   = scnt_q;

    if (bus.sync_clr) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      scnt_d   = '0;
      active_d = sel_eff;
      half_d   = half_eff;
      pend_d   = (sel_eff != active_q);
    end else if (bus.en) begin
      pend_d = (sel_eff != active_q);
      if (active_q == 4'd0) begin
        // Stopped: a valid code starts counting from zero right away.
        cnt_d = '0;
        if (sel_eff != 4'd0) begin
          active_d = sel_eff;
          half_d   = half_eff;
        end
      end else if (at_term) begin
        cnt_d = '0;
        if (clk_q) begin
          clk_d = 1'b0;
        end else if (sel_eff == 4'd0) begin
          // Stop lands on a rising boundary: suppress the edge entirely.
          active_d = 4'd0;
        end else begin
          // Rising boundary: adopt the requested code (and refresh the custom
          // shadow) so the high phase already runs at the new half-period.
          active_d = sel_eff;
          half_d   = half_eff;
          clk_d    = 1'b1;
          stb_d    = 1'b1;
          scnt_d   = scnt_q + SCNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      half_q   <= '0;
      clk_q    <= 1'b0;
      stb_q    <= 1'b0;
      active_q <= 4'd0;
      pend_q   <= 1'b0;
      scnt_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      clk_q    <= clk_d;
      stb_q    <= stb_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      scnt_q   <= scnt_d;
    end
  end

  assign bus.clk_out        = clk_q;
  assign bus.sample_stb     = stb_q;
  assign bus.active_sel     = active_q;
  assign bus.switch_pending = pend_q;
  assign bus.sample_count   = scnt_q;

endmodule

// File: tb/tb_sample_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_sample_clk_gen
// Directed timing scenarios plus a randomized run against a countdown-based
// reference model. Inputs change and outputs are sampled on clk_in negedges.
// ---------------------------------------------------------------------------
module tb_sample_clk_gen;
  localparam int CNT_W  = 32;
  localparam int SCNT_W = 8;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   nchk   = 0;
  int   nfail  = 0;

  sample_clk_gen_if #(.CNT_W(CNT_W), .SCNT_W(SCNT_W)) bus ();

  sample_clk_gen #(
    .CLK_FREQ_HZ(100000000),
    .CNT_W      (CNT_W),
    .SCNT_W     (SCNT_W)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  // Tracks cycles left until the next clk_out boundary (countdown).
  function automatic longint unsigned model_half(input logic [3:0] c, input logic [31:0] dh);
    int unsigned rates [10] = '{100000, 50000, 20000, 10000, 5000, 2000, 1000, 500, 200, 100};
    if (c >= 4'd1 && c <= 4'd10) return 64'd100000000 / (64'd2 * rates[c - 4'd1]);
    if (c == 4'd15) return longint'(dh);
    return 0;
  endfunction

  longint unsigned mh;
  logic [3:0]      me;
  assign mh = model_half(bus.sel, bus.div_half);
  assign me = (mh == 0) ? 4'd0 : bus.sel;

  logic [3:0]        m_code;
  longint unsigned   m_half, m_left;
  logic              m_level, m_stb, m_pend;
  logic [SCNT_W-1:0] m_count;

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      m_code <= 0; m_half <= 0; m_left <= 0; m_level <= 0;
      m_stb <= 0; m_pend <= 0; m_count <= 0;
    end else begin
      m_stb <= 1'b0;
      if (bus.sync_clr) begin
        m_code <= me; m_half <= mh; m_left <= mh; m_level <= 1'b0;
        m_count <= 0; m_pend <= (me != m_code);
      end else if (bus.en) begin
        m_pend <= (me != m_code);
        if (m_code == 4'd0) begin
          if (me != 4'd0) begin m_code <= me; m_half <= mh; m_left <= mh; end
        end else if (m_left > 1) begin
          m_left <= m_left - 1;
        end else if (m_level) begin
          m_level <= 1'b0; m_left <= m_half;
        end else if (me == 4'd0) begin
          m_code <= 4'd0;
        end else begin
          m_code <= me; m_half <= mh; m_left <= mh; m_level <= 1'b1;
          m_stb <= 1'b1; m_count <= m_count + 8'd1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_level(input logic lvl, input int max, output int cycles, output bit to);
    cycles = 0; to = 0;
    while (bus.clk_out !== lvl) begin
      @(negedge clk_in);
      cycles++;
      if (cycles > max) begin to = 1; break; end
    end
  endtask

  task automatic pulse_sync_clr(input logic [3:0] s, input logic [31:0] dh);
    bus.sel = s; bus.div_half = dh; bus.sync_clr = 1'b1;
    @(negedge clk_in);
    bus.sync_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int c; bit to; int hi;
    bus.en = 1'b1; bus.sync_clr = 1'b0; bus.sel = 4'd1; bus.div_half = 0;
    #2 rst = 1'b0;
    #1;
    nchk++; if (bus.clk_out !== 1'b0) begin nfail++; $display("FAIL reset_clk_out: got %0b expected 0", bus.clk_out); end
    nchk++; if (bus.sample_stb !== 1'b0) begin nfail++; $display("FAIL reset_stb: got %0b expected 0", bus.sample_stb); end
    nchk++; if (bus.active_sel !== 4'd0) begin nfail++; $display("FAIL reset_active: got %0d expected 0", bus.active_sel); end
    nchk++; if (bus.switch_pending !== 1'b0) begin nfail++; $display("FAIL reset_pending: got %0b expected 0", bus.switch_pending); end
    nchk++; if (bus.sample_count !== 8'd0) begin nfail++; $display("FAIL reset_count: got %0d expected 0", bus.sample_count); end
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    nchk++; if (bus.active_sel !== 4'd1) begin nfail++; $display("FAIL first_apply: got %0d expected 1", bus.active_sel); end
    wait_level(1'b1, 600, c, to);
    nchk++; if (to || c != 500) begin nfail++; $display("FAIL first_rise: got %0d cycles expected 500 (timeout=%0b)", c, to); end
    nchk++; if (bus.sample_stb !== 1'b1) begin nfail++; $display("FAIL stb_at_rise: got %0b expected 1", bus.sample_stb); end
    @(negedge clk_in);
    nchk++; if (bus.sample_stb !== 1'b0) begin nfail++; $display("FAIL stb_one_cycle: got %0b expected 0", bus.sample_stb); end
    wait_level(1'b0, 600, c, to);
    hi = c + 1;
    nchk++; if (to || hi != 500) begin nfail++; $display("FAIL high_phase_1: got %0d expected 500", hi); end
    wait_level(1'b1, 600, c, to);
    nchk++; if (to || c != 500) begin nfail++; $display("FAIL low_phase_1: got %0d expected 500", c); end
    $display("test_reset: first rise and 500/500 duty at code 1 done");
  endtask

  task automatic test_switch;
    int c1, c2, c; bit to1, to2, to;
    repeat (200) @(negedge clk_in);
    bus.sel = 4'd2;
    @(negedge clk_in);
    nchk++; if (bus.switch_pending !== 1'b1 || bus.active_sel !== 4'd1) begin
      nfail++; $display("FAIL switch_pending_set: got pend=%0b act=%0d expected pend=1 act=1", bus.switch_pending, bus.active_sel); end
    wait_level(1'b0, 600, c1, to1);
    wait_level(1'b1, 600, c2, to2);
    nchk++; if (to1 || to2 || (201 + c1 + c2) != 1000) begin
      nfail++; $display("FAIL switch_edge_period: got %0d expected 1000", 201 + c1 + c2); end
    nchk++; if (bus.active_sel !== 4'd2 || bus.sample_stb !== 1'b1) begin
      nfail++; $display("FAIL switch_apply: got act=%0d stb=%0b expected act=2 stb=1", bus.active_sel, bus.sample_stb); end
    @(negedge clk_in);
    nchk++; if (bus.switch_pending !== 1'b0) begin nfail++; $display("FAIL switch_pending_clr: got %0b expected 0", bus.switch_pending); end
    wait_level(1'b0, 1100, c, to);
    nchk++; if (to || c + 1 != 1000) begin nfail++; $display("FAIL high_phase_2: got %0d expected 1000", c + 1); end
    wait_level(1'b1, 1100, c, to);
    nchk++; if (to || c != 1000) begin nfail++; $display("FAIL low_phase_2: got %0d expected 1000", c); end
    $display("test_switch: code 1 -> 2 at rising boundary done");
  endtask

  task automatic test_custom;
    int c1, c2; bit to1, to2;
    pulse_sync_clr(4'd15, 32'd3);
    wait_level(1'b1, 10, c1, to1);
    nchk++; if (to1 || c1 != 3) begin nfail++; $display("FAIL custom_first_rise: got %0d expected 3", c1); end
    wait_level(1'b0, 10, c1, to1);
    wait_level(1'b1, 10, c2, to2);
    nchk++; if (to1 || to2 || c1 + c2 != 6) begin nfail++; $display("FAIL custom_period_3: got %0d expected 6", c1 + c2); end
    @(negedge clk_in);
    bus.div_half = 32'd5;
    wait_level(1'b0, 10, c1, to1);
    wait_level(1'b1, 10, c2, to2);
    nchk++; if (to1 || to2 || 1 + c1 + c2 != 6) begin nfail++; $display("FAIL custom_old_period: got %0d expected 6", 1 + c1 + c2); end
    wait_level(1'b0, 20, c1, to1);
    wait_level(1'b1, 20, c2, to2);
    nchk++; if (to1 || to2 || c1 + c2 != 10) begin nfail++; $display("FAIL custom_period_5: got %0d expected 10", c1 + c2); end
    $display("test_custom: div_half 3 -> 5 done");
  endtask

  task automatic test_stop;
    int c; bit to; bit saw_high, saw_stb;
    pulse_sync_clr(4'd4, 32'd0);
    wait_level(1'b1, 5100, c, to);
    repeat (100) @(negedge clk_in);
    bus.sel = 4'd0;
    wait_level(1'b0, 5100, c, to);
    saw_high = 0; saw_stb = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk_in);
      if (bus.clk_out) saw_high = 1;
      if (bus.sample_stb) saw_stb = 1;
      if (i == 4999) begin
        nchk++; if (bus.active_sel !== 4'd4) begin nfail++; $display("FAIL stop_before_boundary: got %0d expected 4", bus.active_sel); end
      end
    end
    nchk++; if (bus.active_sel !== 4'd0) begin nfail++; $display("FAIL stop_active: got %0d expected 0", bus.active_sel); end
    repeat (20) begin
      @(negedge clk_in);
      if (bus.clk_out) saw_high = 1;
      if (bus.sample_stb) saw_stb = 1;
    end
    nchk++; if (saw_high || saw_stb) begin nfail++; $display("FAIL stop_quiet: got high=%0b stb=%0b expected 0 0", saw_high, saw_stb); end
    bus.sel = 4'd1;
    @(negedge clk_in);
    nchk++; if (bus.active_sel !== 4'd1) begin nfail++; $display("FAIL restart_apply: got %0d expected 1", bus.active_sel); end
    wait_level(1'b1, 600, c, to);
    nchk++; if (to || c != 500) begin nfail++; $display("FAIL restart_rise: got %0d expected 500", c); end
    $display("test_stop: stop at boundary and restart done");
  endtask

  task automatic test_wrap_sync_clr;
    int k; int c; bit to; bit done;
    pulse_sync_clr(4'd15, 32'd1);
    nchk++; if (bus.sample_count !== 8'd0) begin nfail++; $display("FAIL clr_count: got %0d expected 0", bus.sample_count); end
    k = 0; done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk_in);
      if (bus.sample_stb) begin
        k++;
        if (k == 255) begin
          nchk++; if (bus.sample_count !== 8'd255) begin nfail++; $display("FAIL count_255: got %0d expected 255", bus.sample_count); end
        end
        if (k == 256) begin
          nchk++; if (bus.sample_count !== 8'd0) begin nfail++; $display("FAIL count_wrap: got %0d expected 0", bus.sample_count); end
          done = 1;
        end
      end
    end
    nchk++; if (!done) begin nfail++; $display("FAIL wrap_timeout: got %0d strobes expected 256", k); end
    repeat (21) @(negedge clk_in);
    pulse_sync_clr(4'd15, 32'd5);
    nchk++; if (bus.sample_count !== 8'd0 || bus.clk_out !== 1'b0 || bus.sample_stb !== 1'b0) begin
      nfail++; $display("FAIL sync_clr_mid: got cnt=%0d clk=%0b stb=%0b expected 0 0 0", bus.sample_count, bus.clk_out, bus.sample_stb); end
    wait_level(1'b1, 20, c, to);
    nchk++; if (to || c != 5) begin nfail++; $display("FAIL sync_clr_rise: got %0d expected 5", c); end
    $display("test_wrap_sync_clr: count wrap and synchronous clear done");
  endtask

  task automatic test_random;
    logic [3:0] codes [8] = '{4'd0, 4'd1, 4'd11, 4'd15, 4'd15, 4'd15, 4'd15, 4'd2};
    int bad; bad = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      nchk++;
      if (bus.clk_out !== m_level || bus.sample_stb !== m_stb || bus.active_sel !== m_code ||
          bus.switch_pending !== m_pend || bus.sample_count !== m_count) begin
        nfail++; bad++;
        if (bad <= 10)
          $display("FAIL random_cycle %0d: got clk=%0b stb=%0b act=%0d pend=%0b cnt=%0d expected %0b %0b %0d %0b %0d",
                   i, bus.clk_out, bus.sample_stb, bus.active_sel, bus.switch_pending, bus.sample_count,
                   m_level, m_stb, m_code, m_pend, m_count);
      end
      if ($urandom_range(0, 49) == 0) bus.sel = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 19) == 0) bus.div_half = $urandom_range(0, 6);
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.sync_clr = ($urandom_range(0, 199) == 0);
    end
    bus.en = 1'b1; bus.sync_clr = 1'b0;
    $display("test_random: 4000 cycles against model, %0d differing", bad);
  endtask

  task automatic test_en_hold_async_reset;
    int c; bit to; bit saw_low, saw_stb;
    pulse_sync_clr(4'd3, 32'd0);
    wait_level(1'b1, 2600, c, to);
    nchk++; if (to || c != 2500) begin nfail++; $display("FAIL code3_rise: got %0d expected 2500", c); end
    repeat (50) @(negedge clk_in);
    bus.en = 1'b0;
    saw_low = 0; saw_stb = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (!bus.clk_out) saw_low = 1;
      if (bus.sample_stb) saw_stb = 1;
    end
    nchk++; if (saw_low || saw_stb) begin nfail++; $display("FAIL en_hold: got low=%0b stb=%0b expected 0 0", saw_low, saw_stb); end
    bus.en = 1'b1;
    wait_level(1'b0, 2600, c, to);
    nchk++; if (to || c != 2450) begin nfail++; $display("FAIL en_resume: got %0d expected 2450", c); end
    wait_level(1'b1, 2600, c, to);
    repeat (100) @(negedge clk_in);
    #2 rst = 1'b0;
    #1;
    nchk++; if (bus.clk_out !== 1'b0 || bus.sample_stb !== 1'b0 || bus.active_sel !== 4'd0 ||
                bus.switch_pending !== 1'b0 || bus.sample_count !== 8'd0) begin
      nfail++; $display("FAIL async_reset: got clk=%0b stb=%0b act=%0d pend=%0b cnt=%0d expected all 0",
                        bus.clk_out, bus.sample_stb, bus.active_sel, bus.switch_pending, bus.sample_count); end
    @(negedge clk_in);
    rst = 1'b1;
    $display("test_en_hold_async_reset: enable hold and asynchronous reset done");
  endtask

  initial begin
    test_reset();
    test_switch();
    test_custom();
    test_stop();
    test_wrap_sync_clr();
    test_random();
    test_en_hold_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
